tinyalu_resp: RTL

Responder end of the TinyALU start/done operation protocol. It captures operands and opcode when start is asserted and computes the result. Single-cycle ops take 1 cycle; multiply goes through a fixed-latency pipeline. It raises done for exactly one cycle with the result, then waits for start to drop before accepting the next operation. This is the RTL counterpart the testbench BFM drives.

---
 rtl/tinyalu_resp.sv | 85 ++++++++
 1 files changed

// File: rtl/tinyalu_resp.sv
// tinyalu_resp: TinyALU start/done responder with single-cycle ALU ops and fixed-latency multiply.
module tinyalu_resp #(
  parameter int DATA_W      = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  input  logic [2:0]            op,
  input  logic                  start,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
  output logic                  busy
);
  localparam int RW = 2 * DATA_W;
  localparam int CW = $clog2(MUL_LATENCY);
  typedef enum logic [2:0] {IDLE, EXEC, MUL, DONE, REARM} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     result_q, result_d, alu;
  logic              done_q, done_d;
  always_comb
    alu = op_q == 3'b001 ? RW'(a_q) + RW'(b_q) :
          op_q == 3'b010 ? RW'(a_q & b_q) :
          op_q == 3'b011 ? RW'(a_q ^ b_q) :
          op_q == 3'b100 ? RW'(a_q) * RW'(b_q) : '0;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE:
        if (start && op != 3'b000) begin
          a_d  = A;
          b_d  = B;
          op_d = op;
          cnt_d = CW'(MUL_LATENCY - 1);
          state_d = op == 3'b111 ? REARM : op == 3'b100 ? MUL : EXEC;
          if (op == 3'b111) result_d = '0;
        end
      EXEC: begin
        result_d = alu;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      MUL:
        if (cnt_q == '0) begin
          result_d = alu;
          done_d   = 1'b1;
          state_d  = DONE;
        end else cnt_d = cnt_q - CW'(1);
      DONE:  state_d = start ? REARM : IDLE;
      REARM: state_d = start ? REARM : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  assign done   = done_q;
  assign result = result_q;
  assign busy   = state_q == EXEC || state_q == MUL || state_q == DONE;
endmodule
